sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder_pkg.sv | 54 +++++
 rtl/sram_bwe_ram.sv | 32 +++
 rtl/sram_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// Shared constants, decode types and helpers for the SRAM responder.
package sram_responder_pkg;

    localparam int unsigned DefaultAddrWidth = 10;

    // MMIO window is selected by the upper half of the byte address
    localparam logic [15:0] MmioBase      = 16'hBFAF;
    localparam logic [15:0] LedOffset     = 16'hF000;
    localparam logic [15:0] SwitchOffset  = 16'hF004;
    localparam logic [15:0] ScratchOffset = 16'hF008;
    localparam logic [15:0] TimerOffset   = 16'hE000;

    // Target selected by an access; SelNone also marks "no read data yet"
    typedef enum logic [2:0] {
        SelNone,
        SelRam,
        SelLed,
        SelSwitch,
        SelScratch,
        SelTimer
    } sel_e;

    // Replace the bytes of old_word whose enable bit is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Decode a word address (byte address bits [31:2]) to its target
    function automatic sel_e decode_addr(input logic [29:0] word_addr);
        sel_e sel;
        if (word_addr[29:14] != MmioBase) begin
            sel = SelRam;
        end else begin
            case (word_addr[13:0])
                LedOffset[15:2]:     sel = SelLed;
                SwitchOffset[15:2]:  sel = SelSwitch;
                ScratchOffset[15:2]: sel = SelScratch;
                TimerOffset[15:2]:   sel = SelTimer;
                default:             sel = SelNone;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/sram_bwe_ram.sv
// Single-port word RAM: synchronous read, per-byte write, read-before-write.
module sram_bwe_ram
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    // Contents are deliberately not reset so they survive a reset pulse
    logic [31:0] mem [Depth];

    // Read the old word and apply enabled byte lanes on the same edge
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM-style bus responder: RAM plus LED, switch, scratch and timer MMIO registers.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_we,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    sel_e        acc_sel;
    sel_e        sel_d, sel_q;
    logic [31:0] mmio_rdata_d, mmio_rdata_q;
    logic [15:0] led_d, led_q;
    logic [31:0] scratch_d, scratch_q;
    logic [31:0] timer_d, timer_q;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] led_merged;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic        unused_bits;

    assign acc_sel    = decode_addr(sram_addr[31:2]);
    // Gate with rst so an access coinciding with reset never reaches the RAM
    assign ram_en     = sram_en & ~rst & (acc_sel == SelRam);
    assign led_merged = byte_merge({16'h0, led_q}, sram_wdata, {2'b00, sram_we[1:0]});
    assign unused_bits = ^{sram_addr[1:0], led_merged[31:16]};

    sram_bwe_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (sram_we),
        .addr  (sram_addr[ADDR_WIDTH+1:2]),
        .wdata (sram_wdata),
        .rdata (ram_rdata)
    );

    // MMIO read capture, register writes and free-running timer
    always_comb begin
        sel_d        = sel_q;
        mmio_rdata_d = mmio_rdata_q;
        led_d        = led_q;
        scratch_d    = scratch_q;
        timer_d      = timer_q + 32'd1;
        if (sram_en) begin
            sel_d = acc_sel;
            case (acc_sel)
                SelLed: begin
                    mmio_rdata_d = {16'h0, led_q};
                    led_d        = led_merged[15:0];
                end
                SelSwitch: begin
                    mmio_rdata_d = {24'h0, sw_sync_q};
                end
                SelScratch: begin
                    mmio_rdata_d = scratch_q;
                    scratch_d    = byte_merge(scratch_q, sram_wdata, sram_we);
                end
                SelTimer: begin
                    mmio_rdata_d = timer_q;
                    // A write replaces the increment for this cycle
                    if (|sram_we) begin
                        timer_d = byte_merge(timer_q, sram_wdata, sram_we);
                    end
                end
                default: begin
                    mmio_rdata_d = 32'h0;
                end
            endcase
        end
    end

    // State registers and the two-flop switch synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= SelNone;
            mmio_rdata_q <= 32'h0;
            led_q        <= 16'h0;
            scratch_q    <= 32'h0;
            timer_q      <= 32'h0;
            sw_meta_q    <= 8'h0;
            sw_sync_q    <= 8'h0;
        end else begin
            sel_q        <= sel_d;
            mmio_rdata_q <= mmio_rdata_d;
            led_q        <= led_d;
            scratch_q    <= scratch_d;
            timer_q      <= timer_d;
            sw_meta_q    <= switch;
            sw_sync_q    <= sw_meta_q;
        end
    end

    // sel_q resets to SelNone so read data is zero until the next access
    assign sram_rdata = (sel_q == SelRam) ? ram_rdata : mmio_rdata_q;
    assign led        = led_q;

endmodule
